issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Issue controller for the dual-slot decode stage. It tracks in-flight destination registers in execute and writeback, and produces the per-operand `hazard_select` codes (0–7) consumed by the decode operand muxes. It decides per cycle whether slot 0 and slot 1 issue, split-issue or stall. It also sequences the multi-cycle MUL unit and the LSU completion handshake.

## Interface
- `MUL_LATENCY`, default 3: cycles a MUL/DIV/REM occupies execute (≥1).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: squash the current bundle; no issue this cycle, clears split state.
- `dec_valid0`, `dec_valid1` in 1: slot k holds a decoded instruction.
- `dec_rs1_0`, `dec_rs2_0`, `dec_rd_0`, `dec_rs1_1`, `dec_rs2_1`, `dec_rd_1` in 5 each: register indices.
- `dec_reg_write0`, `dec_reg_write1` in 1: slot writes rd.
- `dec_unit0`, `dec_unit1` in 2: 0=none/branch, 1=AU, 2=MUL, 3=LSU.
- `lsu_data_valid` in 1: LSU result present this cycle.
- `hazard_select1_0`, `hazard_select2_0`, `hazard_select1_1`, `hazard_select2_1` out 3 each: forwarding code per operand.
- `issue0`, `issue1` out 1: slot k enters execute at the next edge.
- `fetch_stall` out 1: hold fetch/decode bundle this cycle.
- `mul_busy` out 1: MUL occupying execute and not done.

## Operation
- State per lane k∈{0,1}:
  - `ex[k]` = {valid, rd, wr, unit}
  - `wb[k]` = {valid, rd, wr}
  - `mul_cnt` (down-counter)
  - `half_done` (slot 0 of the held bundle already issued).
- Done condition for `ex[k]`:
  - AU / none: always done.
  - MUL: `mul_cnt==0`.
  - LSU: `lsu_data_valid`.
- `ex_hold` = any valid `ex[k]` not done.
- When not `ex_hold`, each `ex[k]` moves to `wb[k]`. Otherwise `ex` and `wb` are frozen (in-order pipeline).
- Effective slot-0 valid is `dec_valid0 & ~half_done`.
- Forwarding code for operand r of slot k, first match in this order:
  1. r==0 → 0.
  2. `ex[0]`, `ex[1]` match, where lane j AU → 1+j, MUL → 3+j, LSU → 5.
  3. `wb[0]` → 6, `wb[1]` → 7.
  4. Otherwise 0.
- A match requires valid & wr & rd==r. On equal rd in `ex[0]` and `ex[1]`, `ex[1]` (younger) wins.
- Raw stall: any operand matching an `ex` entry whose unit is MUL or LSU and not done → no issue.
- Split-issue: issue0=1, issue1=0, fetch_stall=1, `half_done` set at edge. Triggered when:
  - slot 1 reads slot 0's rd (slot 0 wr, rd≠0), or
  - both slots unit MUL, or
  - both slots unit LSU.
- Next cycle, slot 1 issues alone into lane 1; `half_done` clears when slot 1 issues or on `flush`.
- `fetch_stall` = `ex_hold` | raw stall | split.
- Issue writes `ex[k]` with the slot's fields; a lane not issued becomes invalid.
- MUL issue loads `mul_cnt = MUL_LATENCY-1`; it decrements to 0 and saturates.
- `flush`: issue0=issue1=0, `half_done` cleared, in-flight state unchanged.

## Timing
- Reset: all `ex`/`wb` invalid, `mul_cnt`=0, `half_done`=0.
  - All outputs 0 except `fetch_stall`, which is 0 at reset.
- Select, issue and stall outputs are combinational from registered state plus decode inputs, valid in the same cycle.
- AU consumer back-to-back: code 1/2 in the cycle after producer issue.
- MUL consumer: stalled MUL_LATENCY-1 cycles, then code 3/4.
- Load consumer: stalled until `lsu_data_valid`, then code 5.
- Reset asserted mid-MUL discards the operation.

## Configuration
- `SCOREBOARD_WB_FWD_EN` defined: codes 6/7 generated as above.
- Undefined: a match found only in `wb` forces a one-cycle stall (regfile written that edge) and the operand then gets code 0; codes 6/7 are never produced.

## Test plan
- Reset, then `dec_valid0`=1 AU rd=5 → issue0=1, all selects 0, fetch_stall=0.
- AU add x5 issued, next cycle slot 0 reads rs1=x5 → `hazard_select1_0`=1; one cycle later → 6.
- Bundle slot 0 writes x7, slot 1 reads x7 → cycle 1: issue0=1, issue1=0, fetch_stall=1; cycle 2: issue1=1, `hazard_select1_1`=1.
- MUL x3 with MUL_LATENCY=3, consumer reads x3 → fetch_stall=1 and mul_busy=1 for 2 cycles, then `hazard_select`=3, issue0=1.
- Load x9, consumer waits, `lsu_data_valid` asserted on cycle 4 → stall cycles 1–3, code 5 and issue on cycle 4.
- `flush` during split-issue hold → issue0=issue1=0, `half_done` cleared; next bundle issues both slots.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Dual-slot issue controller: operand forwarding selects, split-issue/stall control, MUL/LSU sequencing.
// Optional macro SCOREBOARD_WB_FWD_EN enables writeback forwarding (codes 6/7); otherwise wb-only hits stall one cycle.
module issue_scoreboard #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       dec_valid0,
  input  logic       dec_valid1,
  input  logic [4:0] dec_rs1_0,
  input  logic [4:0] dec_rs2_0,
  input  logic [4:0] dec_rd_0,
  input  logic [4:0] dec_rs1_1,
  input  logic [4:0] dec_rs2_1,
  input  logic [4:0] dec_rd_1,
  input  logic       dec_reg_write0,
  input  logic       dec_reg_write1,
  input  logic [1:0] dec_unit0,
  input  logic [1:0] dec_unit1,
  input  logic       lsu_data_valid,
  output logic [2:0] hazard_select1_0,
  output logic [2:0] hazard_select2_0,
  output logic [2:0] hazard_select1_1,
  output logic [2:0] hazard_select2_1,
  output logic       issue0,
  output logic       issue1,
  output logic       fetch_stall,
  output logic       mul_busy
);

  localparam logic [1:0] UNIT_MUL = 2'd2;
  localparam logic [1:0] UNIT_LSU = 2'd3;

  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

  logic [1:0]      ex_valid, ex_wr;
  logic [1:0][4:0] ex_rd;
  logic [1:0][1:0] ex_unit;
  logic [1:0]      wb_valid, wb_wr;
  logic [1:0][4:0] wb_rd;
  logic [CNT_W-1:0] mul_cnt;
  logic            half_done;

  logic [1:0]      ex_done;
  logic            ex_hold;
  logic            slot0_v;
  logic [3:0][4:0] opr;
  logic [3:0]      op_live;
  logic [3:0][2:0] sel;
  logic [3:0]      op_raw;
  logic [3:0]      op_wbw;
  logic [1:0]      hit_ex, hit_wb;
  logic            raw_stall, wb_stall, dep, pair_conflict, go, split;

  function automatic logic [2:0] ex_code(input logic [1:0] unit, input logic lane);
    case (unit)
      UNIT_MUL: ex_code = lane ? 3'd4 : 3'd3;
      UNIT_LSU: ex_code = 3'd5;
      default:  ex_code = lane ? 3'd2 : 3'd1;
    endcase
  endfunction

  always_comb begin
    ex_done = '1;
    for (int unsigned k = 0; k < 2; k++) begin
      case (ex_unit[k])
        UNIT_MUL: ex_done[k] = (mul_cnt == '0);
        UNIT_LSU: ex_done[k] = lsu_data_valid;
        default:  ex_done[k] = 1'b1;
      endcase
    end
  end

  assign ex_hold = |(ex_valid & ~ex_done);
  assign slot0_v = dec_valid0 & ~half_done;

  // Operand order: rs1_0, rs2_0, rs1_1, rs2_1. Lane 1 is younger, so it is checked first.
  always_comb begin
    opr     = {dec_rs2_1, dec_rs1_1, dec_rs2_0, dec_rs1_0};
    op_live = {dec_valid1, dec_valid1, slot0_v, slot0_v};
    sel     = '0;
    op_raw  = '0;
    op_wbw  = '0;
    hit_ex  = '0;
    hit_wb  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        hit_ex[k] = ex_valid[k] & ex_wr[k] & (ex_rd[k] == opr[i]) & (opr[i] != 5'd0);
        hit_wb[k] = wb_valid[k] & wb_wr[k] & (wb_rd[k] == opr[i]) & (opr[i] != 5'd0);
        op_raw[i] = op_raw[i] | (hit_ex[k] & ~ex_done[k] &
                                 ((ex_unit[k] == UNIT_MUL) | (ex_unit[k] == UNIT_LSU)));
      end
      if (hit_ex[1]) begin
        sel[i] = ex_code(ex_unit[1], 1'b1);
      end else if (hit_ex[0]) begin
        sel[i] = ex_code(ex_unit[0], 1'b0);
      end else if (hit_wb[0]) begin
`ifdef SCOREBOARD_WB_FWD_EN
        sel[i] = 3'd6;
`else
        op_wbw[i] = 1'b1;
`endif
      end else if (hit_wb[1]) begin
`ifdef SCOREBOARD_WB_FWD_EN
        sel[i] = 3'd7;
`else
        op_wbw[i] = 1'b1;
`endif
      end
      op_raw[i] = op_raw[i] & op_live[i];
      op_wbw[i] = op_wbw[i] & op_live[i];
    end
  end

  assign hazard_select1_0 = sel[0];
  assign hazard_select2_0 = sel[1];
  assign hazard_select1_1 = sel[2];
  assign hazard_select2_1 = sel[3];

  assign raw_stall     = |op_raw;
  assign wb_stall      = |op_wbw;
  assign dep           = dec_reg_write0 & (dec_rd_0 != 5'd0) &
                         ((dec_rs1_1 == dec_rd_0) | (dec_rs2_1 == dec_rd_0));
  assign pair_conflict = ((dec_unit0 == UNIT_MUL) & (dec_unit1 == UNIT_MUL)) |
                         ((dec_unit0 == UNIT_LSU) & (dec_unit1 == UNIT_LSU));
  assign go            = ~flush & ~ex_hold & ~raw_stall & ~wb_stall;
  assign split         = go & slot0_v & dec_valid1 & (dep | pair_conflict);

  assign issue0      = go & slot0_v;
  assign issue1      = go & dec_valid1 & ~split;
  assign fetch_stall = ex_hold | raw_stall | wb_stall | split;
  assign mul_busy    = (|(ex_valid & {ex_unit[1] == UNIT_MUL, ex_unit[0] == UNIT_MUL})) &
                       (mul_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= '0;
      ex_wr     <= '0;
      ex_rd     <= '0;
      ex_unit   <= '0;
      wb_valid  <= '0;
      wb_wr     <= '0;
      wb_rd     <= '0;
      mul_cnt   <= '0;
      half_done <= 1'b0;
    end else begin
      if (!ex_hold) begin
        wb_valid   <= ex_valid;
        wb_wr      <= ex_wr;
        wb_rd      <= ex_rd;
        ex_valid   <= {issue1, issue0};
        ex_wr      <= {dec_reg_write1, dec_reg_write0};
        ex_rd[0]   <= dec_rd_0;
        ex_rd[1]   <= dec_rd_1;
        ex_unit[0] <= dec_unit0;
        ex_unit[1] <= dec_unit1;
      end
      if ((issue0 && dec_unit0 == UNIT_MUL) || (issue1 && dec_unit1 == UNIT_MUL)) begin
        mul_cnt <= MUL_LOAD;
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 1'b1;
      end
      if (flush || issue1) begin
        half_done <= 1'b0;
      end else if (split) begin
        half_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: driver queues hand-computed expectations, monitor compares each cycle.
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       dec_valid0, dec_valid1;
  logic [4:0] dec_rs1_0, dec_rs2_0, dec_rd_0, dec_rs1_1, dec_rs2_1, dec_rd_1;
  logic       dec_reg_write0, dec_reg_write1;
  logic [1:0] dec_unit0, dec_unit1;
  logic       lsu_data_valid;
  logic [2:0] hazard_select1_0, hazard_select2_0, hazard_select1_1, hazard_select2_1;
  logic       issue0, issue1, fetch_stall, mul_busy;

  localparam logic [1:0] AU  = 2'd1;
  localparam logic [1:0] MUL = 2'd2;
  localparam logic [1:0] LSU = 2'd3;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.MUL_LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid0(dec_valid0), .dec_valid1(dec_valid1),
    .dec_rs1_0(dec_rs1_0), .dec_rs2_0(dec_rs2_0), .dec_rd_0(dec_rd_0),
    .dec_rs1_1(dec_rs1_1), .dec_rs2_1(dec_rs2_1), .dec_rd_1(dec_rd_1),
    .dec_reg_write0(dec_reg_write0), .dec_reg_write1(dec_reg_write1),
    .dec_unit0(dec_unit0), .dec_unit1(dec_unit1),
    .lsu_data_valid(lsu_data_valid),
    .hazard_select1_0(hazard_select1_0), .hazard_select2_0(hazard_select2_0),
    .hazard_select1_1(hazard_select1_1), .hazard_select2_1(hazard_select2_1),
    .issue0(issue0), .issue1(issue1), .fetch_stall(fetch_stall), .mul_busy(mul_busy)
  );

  // Monitor: the DUT presents a fresh decision every cycle; sample mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {issue0, issue1, fetch_stall, mul_busy,
             hazard_select1_0, hazard_select2_0, hazard_select1_1, hazard_select2_1};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got i0/i1/fs/mb=%b sel=%0d,%0d,%0d,%0d expected i0/i1/fs/mb=%b sel=%0d,%0d,%0d,%0d",
                 e.name, act[15:12], act[11:9], act[8:6], act[5:3], act[2:0],
                 e.exp[15:12], e.exp[11:9], e.exp[8:6], e.exp[5:3], e.exp[2:0]);
      end
    end
  end

  function automatic logic [15:0] v(input logic i0, input logic i1, input logic fs, input logic mb,
                                    input logic [2:0] s10, input logic [2:0] s20,
                                    input logic [2:0] s11, input logic [2:0] s21);
    return {i0, i1, fs, mb, s10, s20, s11, s21};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 1'b0; lsu_data_valid = 1'b0;
    dec_valid0 = 1'b0; dec_valid1 = 1'b0;
    dec_rs1_0 = '0; dec_rs2_0 = '0; dec_rd_0 = '0;
    dec_rs1_1 = '0; dec_rs2_1 = '0; dec_rd_1 = '0;
    dec_reg_write0 = 1'b0; dec_reg_write1 = 1'b0;
    dec_unit0 = '0; dec_unit1 = '0;
  endtask

  task automatic slot0(input logic [1:0] u, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    dec_valid0 = 1'b1; dec_reg_write0 = 1'b1; dec_unit0 = u;
    dec_rd_0 = rd; dec_rs1_0 = rs1; dec_rs2_0 = rs2;
  endtask

  task automatic slot1(input logic [1:0] u, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    dec_valid1 = 1'b1; dec_reg_write1 = 1'b1; dec_unit1 = u;
    dec_rd_1 = rd; dec_rs1_1 = rs1; dec_rs2_1 = rs2;
  endtask

  task automatic expect_out(input string name, input logic [15:0] e);
    exp_t x;
    x.name = name;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick(); clr();
      expect_out(name, v(0,0,0,0, 0,0,0,0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    tick();
    expect_out("reset", v(0,0,0,0, 0,0,0,0));

    // AU producer, back-to-back consumer, then writeback-stage consumer
    tick(); rst_n = 1'b1; clr(); slot0(AU, 5, 0, 0);
    expect_out("au_issue", v(1,0,0,0, 0,0,0,0));
    tick(); clr(); slot0(AU, 6, 5, 0);
    expect_out("au_fwd_ex", v(1,0,0,0, 1,0,0,0));
    tick(); clr(); slot0(AU, 8, 5, 0);
`ifdef SCOREBOARD_WB_FWD_EN
    expect_out("au_fwd_wb", v(1,0,0,0, 6,0,0,0));
`else
    expect_out("au_wb_stall", v(0,0,1,0, 0,0,0,0));
`endif
    tick(); clr(); slot0(AU, 8, 5, 0);
    expect_out("wb_retire", v(1,0,0,0, 0,0,0,0));
    idle("idle_a", 2);

    // Split issue on intra-bundle dependency
    tick(); clr(); slot0(AU, 7, 0, 0); slot1(AU, 10, 7, 0);
    expect_out("split_first", v(1,0,1,0, 0,0,0,0));
    tick(); clr(); slot0(AU, 7, 0, 0); slot1(AU, 10, 7, 0);
    expect_out("split_second", v(0,1,0,0, 0,0,1,0));
    idle("idle_b", 2);

    // MUL producer, consumer stalls MUL_LATENCY-1 cycles
    tick(); clr(); slot0(MUL, 3, 0, 0);
    expect_out("mul_issue", v(1,0,0,0, 0,0,0,0));
    tick(); clr(); slot0(AU, 11, 3, 0);
    expect_out("mul_stall1", v(0,0,1,1, 3,0,0,0));
    tick(); clr(); slot0(AU, 11, 3, 0);
    expect_out("mul_stall2", v(0,0,1,1, 3,0,0,0));
    tick(); clr(); slot0(AU, 11, 3, 0);
    expect_out("mul_fwd", v(1,0,0,0, 3,0,0,0));
    idle("idle_c", 2);

    // Load producer, consumer waits for lsu_data_valid on cycle 4
    tick(); clr(); slot0(LSU, 9, 0, 0);
    expect_out("ld_issue", v(1,0,0,0, 0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      tick(); clr(); slot0(AU, 12, 9, 0);
      expect_out("ld_wait", v(0,0,1,0, 5,0,0,0));
    end
    tick(); clr(); slot0(AU, 12, 9, 0); lsu_data_valid = 1'b1;
    expect_out("ld_fwd", v(1,0,0,0, 5,0,0,0));
    idle("idle_d", 2);

    // Flush during split hold, then an independent dual issue
    tick(); clr(); slot0(AU, 7, 0, 0); slot1(AU, 13, 7, 0);
    expect_out("flush_split", v(1,0,1,0, 0,0,0,0));
    tick(); clr(); slot0(AU, 7, 0, 0); slot1(AU, 13, 7, 0); flush = 1'b1;
    expect_out("flush", v(0,0,0,0, 0,0,1,0));
    tick(); clr(); slot0(AU, 14, 0, 0); slot1(AU, 15, 0, 0);
    expect_out("post_flush_dual", v(1,1,0,0, 0,0,0,0));
    idle("idle_e", 2);

    // Two MULs in one bundle: split, second waits for first, then lane-1 MUL forwards code 4
    tick(); clr(); slot0(MUL, 16, 0, 0); slot1(MUL, 17, 0, 0);
    expect_out("mul_mul_split", v(1,0,1,0, 0,0,0,0));
    for (int i = 0; i < 2; i++) begin
      tick(); clr(); slot0(MUL, 16, 0, 0); slot1(MUL, 17, 0, 0);
      expect_out("mul_mul_hold", v(0,0,1,1, 0,0,0,0));
    end
    tick(); clr(); slot0(MUL, 16, 0, 0); slot1(MUL, 17, 0, 0);
    expect_out("mul_mul_second", v(0,1,0,0, 0,0,0,0));
    for (int i = 0; i < 2; i++) begin
      tick(); clr(); slot0(AU, 18, 0, 17);
      expect_out("mul1_stall", v(0,0,1,1, 0,4,0,0));
    end
    tick(); clr(); slot0(AU, 18, 0, 17);
    expect_out("mul1_fwd", v(1,0,0,0, 0,4,0,0));
    idle("idle_f", 2);

    // x0 destination never forces a split
    tick(); clr(); slot0(AU, 0, 0, 0); slot1(AU, 19, 0, 0);
    expect_out("x0_no_split", v(1,1,0,0, 0,0,0,0));
    idle("idle_g", 2);

    // Equal rd in both lanes: lane 1 (younger) wins
    tick(); clr(); slot0(AU, 20, 0, 0); slot1(AU, 20, 0, 0);
    expect_out("same_rd_dual", v(1,1,0,0, 0,0,0,0));
    tick(); clr(); slot0(AU, 21, 20, 0);
    expect_out("younger_wins", v(1,0,0,0, 2,0,0,0));
    idle("idle_h", 2);

    // Reset during MUL discards it
    tick(); clr(); slot0(MUL, 22, 0, 0);
    expect_out("mul_rst_issue", v(1,0,0,0, 0,0,0,0));
    tick(); clr(); rst_n = 1'b0;
    expect_out("rst_mid_mul", v(0,0,0,0, 0,0,0,0));
    tick(); rst_n = 1'b1; clr();
    expect_out("after_rst", v(0,0,0,0, 0,0,0,0));

    tick(); clr();
    tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
